ddr_capture_writer: RTL and testbench
=====================================

# ddr_capture_writer

Capture sequencer that writes a 64-bit sample stream into the 64-entry DDR capture RAM through that RAM's external write port (`DdrCapturesIndex_adr_i` / `_we_i` / `_dat_i`). It runs a circular pre-trigger buffer while armed, then records a programmable number of post-trigger samples. It reports the RAM address of the trigger sample so software can unroll the ring over Wishbone. It sits directly upstream of the register/memory block and is armed from that block's `regA_field0_o`.

## Interface
Parameters:
- `g_addr_width`, 6: RAM address width; depth = 2**g_addr_width.
- `g_data_width`, 64: sample width.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: system clock, same clock as the RAM port.
- `rst_n_i` in 1: asynchronous active-low reset.
- `arm_i` in 1: arm level, driven from `regA_field0_o`. A rising edge arms; going low aborts.
- `trig_i` in 1: trigger. Qualified only when `data_valid_i`=1.
- `data_valid_i` in 1: sample strobe.
- `data_i` in g_data_width: sample.
- `post_count_i` in g_addr_width+1: post-trigger sample count, trigger sample included.
- `mem_adr_o` out g_addr_width: to `DdrCapturesIndex_adr_i`.
- `mem_we_o` out 1: to `DdrCapturesIndex_DdrCaptures_we_i`.
- `mem_dat_o` out g_data_width: to `DdrCapturesIndex_DdrCaptures_dat_i`.
- `busy_o` out 1: state is ARMED or TRIGGERED.
- `done_o` out 1: state is DONE.
- `wrapped_o` out 1: the ring wrapped at least once during this capture.
- `trig_adr_o` out g_addr_width: RAM address holding the trigger sample.

## Operation
States:
- IDLE
- ARMED: pre-trigger, circular writes.
- TRIGGERED: counting post-trigger samples.
- DONE

Transitions:
- Arm: an `arm_i` rising edge (registered edge detect) in IDLE or DONE does the following, then goes to ARMED:
  - `ptr` ← 0, `wrapped_o` ← 0, `trig_adr_o` ← 0.
- Write: in ARMED or TRIGGERED, each `data_valid_i` writes `data_i` at `ptr`, then `ptr` ← `ptr`+1 mod depth.
  - In ARMED, the wrap from depth-1 to 0 sets `wrapped_o`. It stays set until the next arm.
- Trigger: ARMED with `trig_i` & `data_valid_i`:
  - The sample is written at `ptr`, and `trig_adr_o` ← `ptr`.
  - `post_count_i` is sampled at this cycle. P = 1 if the input is 0; P = depth if the input is > depth.
  - If P=1, go to DONE. Otherwise the remaining count ← P-1 and go to TRIGGERED.
- Post-trigger: in TRIGGERED, each valid sample is written and the remaining count decrements. The write made when the count is 1 is the last one, and the state goes to DONE.
- Abort: `arm_i`=0 in ARMED or TRIGGERED goes to IDLE immediately. No further writes are issued; `done_o` stays 0. Abort wins over a simultaneous trigger or last sample.
- DONE: holds until the next `arm_i` rising edge. `arm_i` held high does not re-arm.
- `trig_i` without `data_valid_i`, or outside ARMED, is ignored.
- With P = depth, the post-trigger writes overwrite the whole ring. The last write lands at `trig_adr_o`-1.

## Timing
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; `ptr` 0.
- Write latency: `mem_we_o`, `mem_adr_o` and `mem_dat_o` are asserted exactly 1 cycle after the `data_valid_i` cycle.
- `mem_we_o` is a single-cycle pulse per accepted sample. The interface supports back-to-back samples, one per cycle.
- `done_o` rises in the same cycle as the final `mem_we_o` pulse.
- `trig_adr_o` is updated in the same cycle as the trigger write pulse.
- Arm latency: the first sample accepted is in the cycle after the registered `arm_i` rising edge is seen, which is 2 cycles after `arm_i` rises.
- An asynchronous reset mid-capture forces IDLE and clears `mem_we_o` with no clock required. RAM contents are left as they are.

## Structure
- Package `ddr_capture_pkg` holds:
  - the state enum `t_capture_state` (IDLE, ARMED, TRIGGERED, DONE);
  - `C_CAPTURE_DEPTH` = 64;
  - `C_CAPTURE_AW` = 6.
- Single module; the arm edge detector is inline. No sub-module.

## Test plan
- Reset, then arm; 10 samples 0x1..0xA, trigger on the 4th, `post_count_i`=3 -> writes at addresses 0..5; `trig_adr_o`=3; `done_o` with the write at address 5; `wrapped_o`=0.
- Arm; 70 pre-trigger samples, then trigger with `post_count_i`=2 -> `wrapped_o`=1; `trig_adr_o`=6; final write at address 7; exactly 72 `mem_we_o` pulses.
- `post_count_i`=0, trigger on the first sample -> one write at address 0; `done_o` in the same cycle.
- `post_count_i`=100 -> clamped to 64; 64 post-trigger writes; last address = `trig_adr_o`-1 mod 64.
- Drop `arm_i` in the same cycle as the valid trigger -> IDLE; no write for that sample; `done_o`=0.
- After DONE, hold `arm_i` high 20 cycles -> no re-arm; toggle `arm_i` low then high -> ARMED with `ptr` 0 and `wrapped_o` 0.

Source files
------------

// File: rtl/ddr_capture_writer_pkg.sv
// Shared types and constants for the DDR capture sequencer.
package ddr_capture_pkg;

  localparam int C_CAPTURE_DEPTH = 64;
  localparam int C_CAPTURE_AW    = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    DONE      = 2'd3
  } t_capture_state;

endpackage

// File: rtl/ddr_capture_writer_if.sv
// Write port of the DDR capture RAM, driven by the capture sequencer.
interface ddr_capture_writer_if import ddr_capture_pkg::*; #(
  parameter int g_addr_width = C_CAPTURE_AW,
  parameter int g_data_width = 64
) ();

  logic [g_addr_width-1:0] mem_adr_o;
  logic                    mem_we_o;
  logic [g_data_width-1:0] mem_dat_o;

  modport master (output mem_adr_o, output mem_we_o, output mem_dat_o);
  modport slave  (input  mem_adr_o, input  mem_we_o, input  mem_dat_o);

endinterface

// File: rtl/ddr_capture_writer.sv
// Pre/post-trigger capture sequencer: circular pre-trigger ring, then a
// programmable number of post-trigger samples into the capture RAM.
module ddr_capture_writer import ddr_capture_pkg::*; #(
  parameter int g_addr_width = C_CAPTURE_AW,
  parameter int g_data_width = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    arm_i,
  input  logic                    trig_i,
  input  logic                    data_valid_i,
  input  logic [g_data_width-1:0] data_i,
  input  logic [g_addr_width:0]   post_count_i,
  ddr_capture_writer_if.master    mem,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    wrapped_o,
  output logic [g_addr_width-1:0] trig_adr_o
);

  localparam logic [g_addr_width:0]   C_DEPTH_W  = {1'b1, {g_addr_width{1'b0}}};
  localparam logic [g_addr_width:0]   C_ONE_W    = {{g_addr_width{1'b0}}, 1'b1};
  localparam logic [g_addr_width-1:0] C_PTR_LAST = {g_addr_width{1'b1}};
  localparam logic [g_addr_width-1:0] C_PTR_ZERO = {g_addr_width{1'b0}};

  t_capture_state          state_r;
  t_capture_state          state_nxt_s;
  logic                    arm_d_r;
  logic                    arm_rise_r;
  logic [g_addr_width-1:0] ptr_r;
  logic [g_addr_width-1:0] ptr_nxt_s;
  logic [g_addr_width:0]   remain_r;
  logic [g_addr_width:0]   remain_nxt_s;
  logic [g_addr_width:0]   post_clamp_s;
  logic                    accept_s;
  logic                    wrapped_nxt_s;
  logic [g_addr_width-1:0] trig_adr_nxt_s;
  logic                    busy_nxt_s;
  logic                    done_nxt_s;

  // Abort (arm low) suppresses the write of the sample in the same cycle.
  assign accept_s = ((state_r == ARMED) || (state_r == TRIGGERED)) && arm_i && data_valid_i;

  // Post-trigger length clamped to 1..depth, trigger sample included.
  always_comb begin
    post_clamp_s = post_count_i;
    if (post_count_i == {(g_addr_width+1){1'b0}}) begin
      post_clamp_s = C_ONE_W;
    end else if (post_count_i > C_DEPTH_W) begin
      post_clamp_s = C_DEPTH_W;
    end else begin
      post_clamp_s = post_count_i;
    end
  end

  // Registered arm edge detector.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      arm_d_r    <= 1'b0;
      arm_rise_r <= 1'b0;
    end else begin
      arm_d_r    <= arm_i;
      arm_rise_r <= arm_i & ~arm_d_r;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (arm_rise_r) begin
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ARMED: begin
        if (!arm_i) begin
          state_nxt_s = IDLE;
        end else if (data_valid_i && trig_i) begin
          state_nxt_s = (post_clamp_s == C_ONE_W) ? DONE : TRIGGERED;
        end else begin
          state_nxt_s = ARMED;
        end
      end
      TRIGGERED: begin
        if (!arm_i) begin
          state_nxt_s = IDLE;
        end else if (data_valid_i && (remain_r == C_ONE_W)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = TRIGGERED;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the pointer, post counter and status outputs.
  always_comb begin
    ptr_nxt_s      = ptr_r;
    remain_nxt_s   = remain_r;
    wrapped_nxt_s  = wrapped_o;
    trig_adr_nxt_s = trig_adr_o;
    if (((state_r == IDLE) || (state_r == DONE)) && arm_rise_r) begin
      ptr_nxt_s      = C_PTR_ZERO;
      wrapped_nxt_s  = 1'b0;
      trig_adr_nxt_s = C_PTR_ZERO;
    end else if (accept_s) begin
      ptr_nxt_s = ptr_r + 1'b1;
      if (state_r == ARMED) begin
        if (ptr_r == C_PTR_LAST) begin
          wrapped_nxt_s = 1'b1;
        end else begin
          wrapped_nxt_s = wrapped_o;
        end
        if (trig_i) begin
          trig_adr_nxt_s = ptr_r;
          remain_nxt_s   = post_clamp_s - C_ONE_W;
        end else begin
          trig_adr_nxt_s = trig_adr_o;
        end
      end else begin
        remain_nxt_s = remain_r - C_ONE_W;
      end
    end else begin
      ptr_nxt_s = ptr_r;
    end
    busy_nxt_s = (state_nxt_s == ARMED) || (state_nxt_s == TRIGGERED);
    done_nxt_s = (state_nxt_s == DONE);
  end

  // Registered datapath and outputs; RAM port updates only on accepted samples.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_r         <= C_PTR_ZERO;
      remain_r      <= {(g_addr_width+1){1'b0}};
      wrapped_o     <= 1'b0;
      trig_adr_o    <= C_PTR_ZERO;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      mem.mem_we_o  <= 1'b0;
      mem.mem_adr_o <= C_PTR_ZERO;
      mem.mem_dat_o <= {g_data_width{1'b0}};
    end else begin
      ptr_r        <= ptr_nxt_s;
      remain_r     <= remain_nxt_s;
      wrapped_o    <= wrapped_nxt_s;
      trig_adr_o   <= trig_adr_nxt_s;
      busy_o       <= busy_nxt_s;
      done_o       <= done_nxt_s;
      mem.mem_we_o <= accept_s;
      if (accept_s) begin
        mem.mem_adr_o <= ptr_r;
        mem.mem_dat_o <= data_i;
      end else begin
        mem.mem_adr_o <= mem.mem_adr_o;
        mem.mem_dat_o <= mem.mem_dat_o;
      end
    end
  end

endmodule

// File: tb/tb_ddr_capture_writer.sv
// Self-checking bench for ddr_capture_writer: directed table, corner sequences
// and randomized traffic against a cycle-level behavioural model.
module tb_ddr_capture_writer;

  localparam int AW    = 6;
  localparam int DW    = 64;
  localparam int DEPTH = 64;

  localparam int M_IDLE = 0, M_PRE = 1, M_POST = 2, M_FINISHED = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0, trig = 1'b0, valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic [AW:0]   post_count = '0;
  logic          busy, done, wrapped;
  logic [AW-1:0] trig_adr;

  ddr_capture_writer_if #(.g_addr_width(AW), .g_data_width(DW)) mem_if ();

  ddr_capture_writer #(.g_addr_width(AW), .g_data_width(DW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .arm_i(arm), .trig_i(trig),
    .data_valid_i(valid), .data_i(data), .post_count_i(post_count),
    .mem(mem_if), .busy_o(busy), .done_o(done), .wrapped_o(wrapped),
    .trig_adr_o(trig_adr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: what the outputs must look like after each edge
  int            m_mode, m_ptr, m_left, m_adr, m_trig;
  bit            m_we, m_wrapped, m_arm_q1, m_arm_q2;
  logic [DW-1:0] m_dat;

  int seen_we;
  int last_adr;

  typedef struct {
    int n_pre;
    int post;
    bit abort;
    int n_after;
    int exp_writes;
    int exp_last;
    int exp_trig;
    bit exp_wrapped;
    bit exp_done;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_IDLE; m_ptr = 0; m_left = 0; m_adr = 0; m_trig = 0;
    m_we = 0; m_wrapped = 0; m_arm_q1 = 0; m_arm_q2 = 0; m_dat = '0;
  endfunction

  function automatic void model_step();
    bit armed_edge;
    int p;
    armed_edge = m_arm_q1 && !m_arm_q2;
    m_we = 0;
    if (m_mode == M_IDLE || m_mode == M_FINISHED) begin
      if (armed_edge) begin
        m_mode = M_PRE; m_ptr = 0; m_wrapped = 0; m_trig = 0;
      end
    end else if (!arm) begin
      m_mode = M_IDLE;
    end else if (valid) begin
      m_we = 1; m_adr = m_ptr; m_dat = data;
      if (m_mode == M_PRE) begin
        if (m_ptr == DEPTH - 1) m_wrapped = 1;
        if (trig) begin
          m_trig = m_ptr;
          p = (post_count == 0) ? 1 : ((int'(post_count) > DEPTH) ? DEPTH : int'(post_count));
          m_left = p - 1;
          m_mode = (m_left == 0) ? M_FINISHED : M_POST;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = M_FINISHED;
      end
      m_ptr = (m_ptr + 1) % DEPTH;
    end
    m_arm_q2 = m_arm_q1;
    m_arm_q1 = arm;
  endfunction

  task automatic tick();
    logic [79:0] exp_v, act_v;
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
    if (mem_if.mem_we_o === 1'b1) begin
      seen_we++;
      last_adr = int'(mem_if.mem_adr_o);
    end
    exp_v = {m_we, m_we ? 6'(m_adr) : 6'd0, m_we ? m_dat : 64'd0,
             (m_mode == M_PRE || m_mode == M_POST), (m_mode == M_FINISHED),
             m_wrapped, 6'(m_trig)};
    act_v = {mem_if.mem_we_o, m_we ? mem_if.mem_adr_o : 6'd0, m_we ? mem_if.mem_dat_o : 64'd0,
             busy, done, wrapped, trig_adr};
    chk("cycle_model", act_v, exp_v);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int total;
    arm = 0; valid = 0; trig = 0;
    repeat (3) tick();
    arm = 1;
    tick(); tick();
    seen_we = 0; last_adr = -1;
    post_count = 7'(v.post);
    total = v.n_pre + 1 + v.n_after;
    for (int i = 0; i < total; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        valid = 0; trig = 1'($urandom_range(0, 1));
        tick();
      end
      valid = 1;
      data  = {$urandom, $urandom};
      trig  = (i == v.n_pre) ? 1'b1 : ((i > v.n_pre) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (v.abort && i == v.n_pre) arm = 0;
      tick();
    end
    valid = 0; trig = 0;
    tick(); tick();
    chk($sformatf("v%0d_writes", idx), seen_we, v.exp_writes);
    chk($sformatf("v%0d_last_adr", idx), last_adr, v.exp_last);
    chk($sformatf("v%0d_trig_adr", idx), trig_adr, v.exp_trig);
    chk($sformatf("v%0d_wrapped", idx), wrapped, v.exp_wrapped);
    chk($sformatf("v%0d_done", idx), done, v.exp_done);
  endtask

  initial begin
    //        pre post abort after writes last trig wrap done
    vecs[0] = '{3,   3,  0,   6,    6,    5,   3,  0,   1};
    vecs[1] = '{4,   3,  1,   2,    4,    3,   0,  0,   0};
    vecs[2] = '{0,   0,  0,   3,    1,    0,   0,  0,   1};
    vecs[3] = '{5, 100,  0,  67,   69,    4,   5,  0,   1};
    vecs[4] = '{70,  2,  0,   5,   72,    7,   6,  1,   1};

    model_reset();
    rst_n = 0;
    tick(); tick();
    chk("reset_we", mem_if.mem_we_o, 1'b0);
    chk("reset_busy_done", {busy, done, wrapped}, 3'b000);
    chk("reset_trig_adr", trig_adr, 6'd0);
    rst_n = 1;
    tick();

    // arm latency: first sample accepted two cycles after arm rises
    seen_we = 0;
    arm = 1; valid = 1; data = 64'h0123_4567_89ab_cdef;
    tick(); tick();
    chk("arm_latency_no_early_write", seen_we, 0);
    tick();
    chk("arm_latency_first_write", {mem_if.mem_we_o, mem_if.mem_adr_o}, {1'b1, 6'd0});
    valid = 0; arm = 0;
    tick();

    for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

    // DONE holds while arm stays high; a fresh rising edge re-arms cleanly
    seen_we = 0;
    for (int i = 0; i < 20; i++) begin
      valid = 1; trig = 1; data = {$urandom, $urandom};
      tick();
    end
    chk("hold_no_write", seen_we, 0);
    chk("hold_done", {busy, done}, 2'b01);
    valid = 0; trig = 0; arm = 0;
    tick();
    arm = 1;
    tick(); tick();
    chk("rearm_state", {busy, done, wrapped, trig_adr}, {1'b1, 1'b0, 1'b0, 6'd0});
    valid = 1; data = 64'hfeed_face_dead_beef;
    tick();
    chk("rearm_first_write", {mem_if.mem_we_o, mem_if.mem_adr_o, mem_if.mem_dat_o},
        {1'b1, 6'd0, 64'hfeed_face_dead_beef});
    tick();

    // asynchronous reset in the middle of a capture
    chk("pre_reset_we", mem_if.mem_we_o, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("async_reset_we", mem_if.mem_we_o, 1'b0);
    chk("async_reset_busy", busy, 1'b0);
    model_reset();
    valid = 0; arm = 0;
    tick();
    #2 rst_n = 1;
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 60) == 0) arm = ~arm;
      valid      = ($urandom_range(0, 9) < 7);
      trig       = ($urandom_range(0, 19) == 0);
      post_count = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 8));
      data       = {$urandom, $urandom};
      tick();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
